// File: rtl/csla_seq_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : csla_16bit / csla_seq_add_ctrl                               |
// | Description : 16-bit carry-select adder plus a controller that sequences   |
// |               it across WIDTH-bit operands, one chunk per cycle, LSB first. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+

// 16-bit carry-select adder: four 4-bit groups, each precomputing both carry
// hypotheses and picking one once the incoming group carry is known.
module csla_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        cin_i,
    output logic [15:0] sum_o,
    output logic        cout_o
);

    logic [4:0] w_carry;

    assign w_carry[0] = cin_i;

    genvar g;
    generate
        for (g = 0; g < 4; g = g + 1) begin : g_group
            logic [4:0] w_r0;
            logic [4:0] w_r1;
            assign w_r0 = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]};
            assign w_r1 = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]} + 5'd1;
            assign sum_o[4*g +: 4] = w_carry[g] ? w_r1[3:0] : w_r0[3:0];
            assign w_carry[g+1]    = w_carry[g] ? w_r1[4]   : w_r0[4];
        end
    endgenerate

    assign cout_o = w_carry[4];

endmodule

// Multi-cycle wide adder/subtractor controller built around one csla_16bit.
module csla_seq_add_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / 16;
    localparam int c_IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [c_IDXW-1:0]       idx_q, idx_d;
    logic [NCHUNK-1:0][15:0] a_q, a_d;
    logic [NCHUNK-1:0][15:0] b_q, b_d;
    logic [NCHUNK-1:0][15:0] sum_q, sum_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;
    logic                    ovf_q, ovf_d;

    logic                    w_accept;
    logic                    w_last;
    logic [15:0]             w_add_sum;
    logic                    w_add_cout;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (idx_q == c_IDXW'(NCHUNK - 1));

    csla_16bit u_adder (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (carry_q),
        .sum_o  (w_add_sum),
        .cout_o (w_add_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a DONE handoff with a waiting request goes straight back to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: if (w_accept) state_d = c_ST_RUN;
            c_ST_RUN:  if (w_last)   state_d = c_ST_DONE;
            c_ST_DONE: begin
                if (w_accept)       state_d = c_ST_RUN;
                else if (out_ready) state_d = c_ST_IDLE;
            end
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = (state_q == c_ST_IDLE) | ((state_q == c_ST_DONE) & out_ready);
        out_valid = (state_q == c_ST_DONE);
        busy      = (state_q == c_ST_RUN);
    end

    // Datapath next values: capture on accept, fill one result chunk per RUN cycle.
    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (w_accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            idx_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == c_ST_RUN) begin
            sum_d[idx_q] = w_add_sum;
            carry_d      = w_add_cout;
            // Only the value computed on the top chunk survives to DONE.
            ovf_d = (a_q[NCHUNK-1][15] == b_q[NCHUNK-1][15]) &
                    (w_add_sum[15] != a_q[NCHUNK-1][15]);
            if (w_last) begin
                cout_d = w_add_cout;
            end else begin
                idx_d = idx_q + c_IDXW'(1);
            end
        end
    end

    // Datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_csla_seq_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_csla_seq_add_ctrl                                         |
// | Description : Directed self-checking bench for csla_seq_add_ctrl (64-bit). |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_csla_seq_add_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int checks;
    int errors;
    int accept_cnt;

    csla_seq_add_ctrl #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handshakes seen at each rising edge.
    always @(posedge clk) begin
        if (in_valid && in_ready) accept_cnt++;
    end

    // Present a request at a falling edge, hold it through one rising edge,
    // then withdraw it. Returns at the falling edge after the accept edge.
    task automatic issue(input logic [63:0] av, input logic [63:0] bv,
                         input logic cv, input logic sv);
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, reporting how many falling edges it took (bounded).
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_result: out_valid=%0b after %0d cycles, required 1", out_valid, cycles);
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (sum !== 64'd0)      begin errors++; $display("FAIL reset_sum: got %h required 0", sum); end
        checks++; if (cout !== 1'b0)      begin errors++; $display("FAIL reset_cout: got %b required 0", cout); end
        checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf: got %b required 0", ovf); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_carry_ripple();
        int busy_cnt;
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL ripple_early_valid: cycle %0d got %b required 0", i, out_valid); end
            @(negedge clk);
        end
        checks++; if (busy_cnt != 4)        begin errors++; $display("FAIL ripple_busy_cycles: got %0d required 4", busy_cnt); end
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL ripple_latency: out_valid got %b required 1", out_valid); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL ripple_busy_done: got %b required 0", busy); end
        checks++; if (sum !== 64'd0)        begin errors++; $display("FAIL ripple_sum: got %h required 0", sum); end
        checks++; if (cout !== 1'b1)        begin errors++; $display("FAIL ripple_cout: got %b required 1", cout); end
        checks++; if (ovf !== 1'b0)         begin errors++; $display("FAIL ripple_ovf: got %b required 0", ovf); end
        retire();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL ripple_retire: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready); end
    endtask

    task automatic test_subtract();
        int cyc;
        issue(64'd5, 64'd7, 1'b0, 1'b1);
        wait_result(cyc);
        checks++; if (cyc != 4) begin errors++; $display("FAIL sub_latency: got %0d required 4", cyc); end
        checks++; if (sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_5_7_sum: got %h required fffffffffffffffe", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub_5_7_cout: got %b required 0", cout); end
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL sub_5_7_ovf: got %b required 0", ovf); end
        retire();
        issue(64'd7, 64'd5, 1'b1, 1'b1);
        wait_result(cyc);
        checks++; if (sum !== 64'd2) begin errors++; $display("FAIL sub_7_5_sum: got %h required 2", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub_7_5_cout: got %b required 1", cout); end
        checks++; if (ovf !== 1'b0)  begin errors++; $display("FAIL sub_7_5_ovf: got %b required 0", ovf); end
        retire();
    endtask

    task automatic test_overflow();
        int cyc;
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        wait_result(cyc);
        checks++; if (sum !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_add_sum: got %h required 8000000000000000", sum); end
        checks++; if (ovf !== 1'b1)  begin errors++; $display("FAIL ovf_add_ovf: got %b required 1", ovf); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ovf_add_cout: got %b required 0", cout); end
        retire();
        issue(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1);
        wait_result(cyc);
        checks++; if (sum !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL ovf_sub_sum: got %h required 7fffffffffffffff", sum); end
        checks++; if (ovf !== 1'b1)  begin errors++; $display("FAIL ovf_sub_ovf: got %b required 1", ovf); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ovf_sub_cout: got %b required 1", cout); end
        retire();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        issue(64'd1, 64'd2, 1'b0, 1'b0);
        wait_result(cyc);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || sum !== 64'd3 || cout !== 1'b0 || ovf !== 1'b0 || in_ready !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d unstable cycles, required 0", bad); end
        out_ready = 1'b1; in_valid = 1'b1;
        a = 64'h0000_FFFF_0000_FFFF; b = 64'd1; cin = 1'b1; sub = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL handoff_in_ready: got %b required 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || sum !== 64'd0)
            begin errors++; $display("FAIL handoff_state: busy=%b out_valid=%b sum=%h required 1/0/0", busy, out_valid, sum); end
        wait_result(cyc);
        checks++; if (cyc != 4) begin errors++; $display("FAIL handoff_latency: got %0d required 4", cyc); end
        checks++; if (sum !== 64'h0000_FFFF_0001_0001) begin errors++; $display("FAIL handoff_sum: got %h required 0000ffff00010001", sum); end
        retire();
    endtask

    task automatic test_reset_mid();
        int cyc;
        issue(64'h1234, 64'd1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL midreset_ctrl: in_ready=%b out_valid=%b busy=%b required 1/0/0", in_ready, out_valid, busy); end
        checks++; if (sum !== 64'd0) begin errors++; $display("FAIL midreset_sum: got %h required 0", sum); end
        issue(64'd3, 64'd4, 1'b0, 1'b0);
        wait_result(cyc);
        checks++; if (sum !== 64'd7) begin errors++; $display("FAIL midreset_followup: got %h required 7", sum); end
        retire();
    endtask

    task automatic test_input_stability();
        accept_cnt = 0;
        issue(64'd100, 64'd50, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            sub = k[0]; cin = ~k[0]; in_valid = 1'b1;
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stable_valid: got %b required 1", out_valid); end
        checks++; if (sum !== 64'd50 || cout !== 1'b1) begin errors++; $display("FAIL stable_result: sum=%h cout=%b required 32/1", sum, cout); end
        checks++; if (accept_cnt != 1) begin errors++; $display("FAIL stable_accepts: got %0d required 1", accept_cnt); end
        in_valid = 1'b0;
        retire();
    endtask

    initial begin
        checks = 0; errors = 0; accept_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_carry_ripple();
        test_subtract();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_input_stability();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
